cpu_mem_arbiter: RTL and testbench
==================================

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin between instruction and data on a tie, 0 = data side always wins a tie.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 inst_req_valid  input  1  instruction fetch request pending; inst_addr held stable while high.
REQ-005 inst_addr  input  32  fetch address.
REQ-006 inst_req_ready  output  1  fetch request accepted this cycle.
REQ-007 inst_rdata  output  32  fetch read data, from m_rdata.
REQ-008 inst_rvalid  output  1  fetch read data valid.
REQ-009 inst_rready  input  1  fetch side ready for data.
REQ-010 d_read  input  1  load request pending; its fields are held stable while high.
REQ-011 d_write  input  1  store request pending; its fields are held stable while high.
REQ-012 d_addr  input  32  data address, word-aligned.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_wstrb  input  4  store byte strobes.
REQ-015 d_req_ready  output  1  data request accepted this cycle.
REQ-016 d_rdata  output  32  load data.
REQ-017 d_rvalid  output  1  load data valid.
REQ-018 d_rready  input  1  data side ready for data.
REQ-019 m_req_valid  output  1  request on the unified memory port.
REQ-020 m_we  output  1  1 = write, 0 = read.
REQ-021 m_addr  output  32  memory address.
REQ-022 m_wdata  output  32  memory write data.
REQ-023 m_wstrb  output  4  memory write strobes.
REQ-024 m_req_ready  input  1  memory accepts the request.
REQ-025 m_rdata  input  32  memory read data.
REQ-026 m_rvalid  input  1  memory read data valid.
REQ-027 m_rready  output  1  arbiter accepts the read data.
REQ-028 cnt_inst  output  32  count of accepted instruction requests.
REQ-029 cnt_data  output  32  count of accepted data requests.

Function
REQ-030 FSM states: IDLE, IREQ, IRSP, DREQ, DRSP; one transaction outstanding at a time.
REQ-031 IDLE -> IREQ or DREQ on the arbitration result.
  - Only one side requesting: grant that side.
  - Both requesting, RR_EN=1: grant the side opposite to last_grant.
  - Both requesting, RR_EN=0: grant data.
  - Neither requesting: stay in IDLE.
REQ-032 last_grant register updates on entry to IREQ or DREQ.
REQ-033 Request latency: requester valid in IDLE at cycle t gives m_req_valid=1 at cycle t+1.
REQ-034 IREQ: m_req_valid=1, m_we=0, m_addr=inst_addr; on m_req_ready, inst_req_ready=1 that same cycle and the next state is IRSP.
REQ-035 DREQ: m_req_valid=1, m_we=d_write, m_addr=d_addr, m_wdata=d_wdata, m_wstrb=d_wstrb; on m_req_ready, d_req_ready=1 that same cycle; the next state is IDLE if write, DRSP if read.
REQ-036 If d_read and d_write are both 1, the request is treated as a write.
REQ-037 IRSP: inst_rvalid=m_rvalid, inst_rdata=m_rdata, m_rready=inst_rready; on m_rvalid & inst_rready, go to IDLE.
REQ-038 DRSP: same as IRSP using the d_ response signals.
REQ-039 Outputs outside their states:
  - m_req_valid, inst_req_ready and d_req_ready are 0 outside IREQ/DREQ.
  - inst_rvalid and d_rvalid are 0 outside IRSP/DRSP.
  - m_rready is 0 outside IRSP/DRSP.
  - m_rvalid arriving outside a RSP state is ignored.
REQ-040 A store never asserts d_rvalid.
REQ-041 m_wdata and m_wstrb are 0 when m_we=0.
REQ-042 Counters increment by 1 on each request handshake of their side and wrap modulo 2^32.
REQ-043 A new request arriving while a response completes waits for IDLE; there is no back-to-back bypass.

Reset
REQ-044 rst=1 forces the state to IDLE and last_grant to DATA, so instruction wins the first tie; cnt_inst and cnt_data are cleared to 0.
REQ-045 Reset mid-transaction abandons the transaction: all valid and ready outputs are 0 in the cycle after rst is sampled.

Structure
REQ-046 Package cpu_mem_arb_pkg holds the one-hot 5-bit state localparams and the GRANT_INST/GRANT_DATA constants.
REQ-047 One sub-module, rr_arb2 (two-requester round-robin grant with last_grant register), is instantiated once.

Verification
REQ-048 Instruction read alone:
  - Stimulus: inst_addr=0x100; m_req_ready=1 at once; m_rvalid with m_rdata=0x00500093 two cycles later.
  - Response: m_req_valid at t+1; inst_rvalid with 0x00500093; cnt_inst=1.
REQ-049 Store:
  - Stimulus: d_write, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0xF.
  - Response: m_we=1 with the same fields; back to IDLE after the handshake; d_rvalid never 1; cnt_data=1.
REQ-050 Tie with RR_EN=1:
  - Stimulus: inst and data requests held continuously for three transactions.
  - Response: grant order inst, data, inst.
REQ-051 Tie with RR_EN=0:
  - Stimulus: same as REQ-050.
  - Response: data granted every time.
REQ-052 Backpressure:
  - Stimulus: m_req_ready=0 for 5 cycles; then m_rvalid=1 with d_rready=0 for 3 cycles.
  - Response: m_req_valid and fields stable throughout; m_rready=0 until d_rready=1.
REQ-053 Reset in DRSP:
  - Stimulus: assert rst while in DRSP.
  - Response: next cycle IDLE; all valid and ready outputs 0; counters 0.

Source files
------------

// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg
//   Shared constants for the CPU memory arbiter:
//   - one-hot FSM state encodings and the matching state enum
//   - grant identifiers used by the two-way round-robin arbiter
package cpu_mem_arb_pkg;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_IREQ = 5'b00010;
  localparam logic [4:0] ST_IRSP = 5'b00100;
  localparam logic [4:0] ST_DREQ = 5'b01000;
  localparam logic [4:0] ST_DRSP = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE = ST_IDLE,
    S_IREQ = ST_IREQ,
    S_IRSP = ST_IRSP,
    S_DREQ = ST_DREQ,
    S_DRSP = ST_DRSP
  } state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-requester arbiter (instruction vs data) with a last_grant register.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     req_inst_i        instruction side requesting
//     req_data_i        data side requesting
//     take_i            grant is consumed this cycle (updates last_grant)
//     gnt_o             selected side: GRANT_INST or GRANT_DATA
import cpu_mem_arb_pkg::*;

module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_inst_i,
  input  logic req_data_i,
  input  logic take_i,
  output logic gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Data wins when it is alone, when ties are fixed-priority, or when
  // instruction had the previous grant.
  always_comb begin
    gnt_o = GRANT_INST;
    if (req_data_i && (!req_inst_i || !RR_EN || last_grant_q == GRANT_INST)) begin
      gnt_o = GRANT_DATA;
    end
  end

  assign last_grant_d = take_i ? gnt_o : last_grant_q;

  // Reset to DATA so that the first tie goes to the instruction side.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= GRANT_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
//   Arbitrates an instruction-fetch port and a load/store port onto one
//   memory port, one transaction outstanding at a time.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     inst_req_valid/inst_addr       fetch request in, inst_req_ready out
//     inst_rdata/inst_rvalid         fetch response out, inst_rready in
//     d_read/d_write/d_addr/...      load/store request in, d_req_ready out
//     d_rdata/d_rvalid               load response out, d_rready in
//     m_req_valid/m_we/m_addr/...    memory request out, m_req_ready in
//     m_rdata/m_rvalid               memory response in, m_rready out
//     cnt_inst/cnt_data              accepted-request counters (wrap)
//
//   state | meaning
//   IDLE  | no transaction, arbitrate pending requests
//   IREQ  | fetch request presented on memory port
//   IRSP  | waiting for fetch read data
//   DREQ  | load/store request presented on memory port
//   DRSP  | waiting for load read data
import cpu_mem_arb_pkg::*;

module cpu_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_valid,
  input  logic [31:0] inst_addr,
  output logic        inst_req_ready,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  input  logic        inst_rready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_req_ready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic        m_req_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_req_ready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] cnt_inst,
  output logic [31:0] cnt_data
);

  state_e      state_q;
  logic [31:0] cnt_inst_q;
  logic [31:0] cnt_data_q;
  logic        d_req;
  logic        take;
  logic        gnt;
  logic        in_ireq, in_irsp, in_dreq, in_drsp;

  assign d_req = d_read | d_write;
  assign take  = (state_q == S_IDLE) && (inst_req_valid || d_req);

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_inst_i (inst_req_valid),
    .req_data_i (d_req),
    .take_i     (take),
    .gnt_o      (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_inst_q <= 32'd0;
      cnt_data_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (take) state_q <= (gnt == GRANT_DATA) ? S_DREQ : S_IREQ;
        S_IREQ: if (m_req_ready) begin
          state_q    <= S_IRSP;
          cnt_inst_q <= cnt_inst_q + 32'd1;
        end
        // d_write set means a store, even if d_read is also set.
        S_DREQ: if (m_req_ready) begin
          state_q    <= d_write ? S_IDLE : S_DRSP;
          cnt_data_q <= cnt_data_q + 32'd1;
        end
        S_IRSP: if (m_rvalid && inst_rready) state_q <= S_IDLE;
        S_DRSP: if (m_rvalid && d_rready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ireq = (state_q == S_IREQ);
  assign in_irsp = (state_q == S_IRSP);
  assign in_dreq = (state_q == S_DREQ);
  assign in_drsp = (state_q == S_DRSP);

  assign m_req_valid    = in_ireq | in_dreq;
  assign m_we           = in_dreq & d_write;
  assign m_addr         = in_ireq ? inst_addr : (in_dreq ? d_addr : 32'd0);
  assign m_wdata        = m_we ? d_wdata : 32'd0;
  assign m_wstrb        = m_we ? d_wstrb : 4'd0;
  assign inst_req_ready = in_ireq & m_req_ready;
  assign d_req_ready    = in_dreq & m_req_ready;

  assign inst_rvalid = in_irsp & m_rvalid;
  assign d_rvalid    = in_drsp & m_rvalid;
  assign inst_rdata  = m_rdata;
  assign d_rdata     = m_rdata;
  assign m_rready    = (in_irsp & inst_rready) | (in_drsp & d_rready);

  assign cnt_inst = cnt_inst_q;
  assign cnt_data = cnt_data_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  localparam bit G_INST = 1'b0;
  localparam bit G_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid;
  logic [31:0] inst_addr;
  logic        inst_rready;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_rready;
  logic        m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  logic        inst_req_ready, inst_rvalid, d_req_ready, d_rvalid;
  logic        m_req_valid, m_we, m_rready;
  logic [31:0] inst_rdata, d_rdata, m_addr, m_wdata, cnt_inst, cnt_data;
  logic [3:0]  m_wstrb;

  logic        inst_req_ready_0, inst_rvalid_0, d_req_ready_0, d_rvalid_0;
  logic        m_req_valid_0, m_we_0, m_rready_0;
  logic [31:0] inst_rdata_0, d_rdata_0, m_addr_0, m_wdata_0, cnt_inst_0, cnt_data_0;
  logic [3:0]  m_wstrb_0;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid), .inst_rready(inst_rready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_req_ready(d_req_ready), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .m_req_valid(m_req_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_req_ready(m_req_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .cnt_inst(cnt_inst), .cnt_data(cnt_data)
  );

  cpu_mem_arbiter #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ready(inst_req_ready_0),
    .inst_rdata(inst_rdata_0), .inst_rvalid(inst_rvalid_0), .inst_rready(inst_rready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_req_ready(d_req_ready_0), .d_rdata(d_rdata_0), .d_rvalid(d_rvalid_0), .d_rready(d_rready),
    .m_req_valid(m_req_valid_0), .m_we(m_we_0), .m_addr(m_addr_0), .m_wdata(m_wdata_0),
    .m_wstrb(m_wstrb_0), .m_req_ready(m_req_ready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rready(m_rready_0), .cnt_inst(cnt_inst_0), .cnt_data(cnt_data_0)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Reference arbitration rule.
  function automatic bit exp_grant(input bit pi, input bit pd, input bit last, input bit rr);
    if (pi && pd) return rr ? !last : G_DATA;
    return pd;
  endfunction

  task automatic chk_all_idle(input string tag);
    chk({tag, "_m_req_valid"}, m_req_valid, 0);
    chk({tag, "_inst_req_ready"}, inst_req_ready, 0);
    chk({tag, "_d_req_ready"}, d_req_ready, 0);
    chk({tag, "_inst_rvalid"}, inst_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_m_rready"}, m_rready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  bit          m_last;
  logic [31:0] m_cnt_i, m_cnt_d;
  bit          gq[$];
  bit          gq0[$];
  bit          g, got, p_i, p_d, wr, exp_we;
  int          sel, dk, k, r, q;
  logic [31:0] ia, da, dw, rd;
  logic [3:0]  ds;

  initial begin
    rst = 1'b1;
    inst_req_valid = 0; inst_addr = 0; inst_rready = 0;
    d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_rready = 0;
    m_req_ready = 0; m_rdata = 0; m_rvalid = 0;
    m_last = G_DATA; m_cnt_i = 0; m_cnt_d = 0;

    // Reset state
    cyc(); cyc();
    cyc(); rst = 1'b0; mid();
    chk_all_idle("reset");
    chk("reset_cnt_inst", cnt_inst, m_cnt_i);
    chk("reset_cnt_data", cnt_data, m_cnt_d);

    // Instruction read alone
    cyc(); inst_req_valid = 1; inst_addr = 32'h100; m_req_ready = 1; mid();
    chk("ird_t0_m_req_valid", m_req_valid, 0);
    cyc(); mid();
    chk("ird_t1_m_req_valid", m_req_valid, 1);
    chk("ird_t1_m_addr", m_addr, 32'h100);
    chk("ird_t1_m_we", m_we, 0);
    chk("ird_t1_inst_req_ready", inst_req_ready, 1);
    g = exp_grant(1, 0, m_last, 1); m_last = g; m_cnt_i++;
    cyc(); inst_req_valid = 0; m_req_ready = 0; mid();
    chk("ird_t2_inst_rvalid", inst_rvalid, 0);
    cyc(); m_rvalid = 1; m_rdata = 32'h0050_0093; inst_rready = 1; mid();
    chk("ird_t3_inst_rvalid", inst_rvalid, 1);
    chk("ird_t3_inst_rdata", inst_rdata, 32'h0050_0093);
    chk("ird_t3_m_rready", m_rready, 1);
    cyc(); m_rvalid = 0; inst_rready = 0; mid();
    chk_all_idle("ird_done");
    chk("ird_cnt_inst", cnt_inst, m_cnt_i);

    // Store
    cyc(); d_write = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    m_req_ready = 1; mid();
    cyc(); mid();
    chk("st_m_req_valid", m_req_valid, 1);
    chk("st_m_we", m_we, 1);
    chk("st_m_addr", m_addr, 32'h200);
    chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("st_m_wstrb", m_wstrb, 4'hF);
    chk("st_d_req_ready", d_req_ready, 1);
    chk("st_d_rvalid_req", d_rvalid, 0);
    g = exp_grant(0, 1, m_last, 1); m_last = g; m_cnt_d++;
    cyc(); d_write = 0; m_req_ready = 0; m_rvalid = 1; d_rready = 1; mid();
    chk_all_idle("st_done");
    cyc(); m_rvalid = 0; d_rready = 0; mid();
    chk("st_d_rvalid_after", d_rvalid, 0);
    chk("st_cnt_data", cnt_data, m_cnt_d);

    // Tie: both sides held for three transactions, checked on both variants
    cyc(); inst_req_valid = 1; inst_addr = 32'h400; d_read = 1; d_addr = 32'h500;
    m_req_ready = 1; m_rvalid = 1; m_rdata = 32'h1234_5678; inst_rready = 1; d_rready = 1;
    mid();
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 9) begin
        inst_req_valid = 0; d_read = 0; m_req_ready = 0; m_rvalid = 0;
        inst_rready = 0; d_rready = 0;
      end
      mid();
      if (inst_req_ready) gq.push_back(G_INST);
      if (d_req_ready) gq.push_back(G_DATA);
      if (inst_req_ready_0) gq0.push_back(G_INST);
      if (d_req_ready_0) gq0.push_back(G_DATA);
    end
    chk("tie_rr_count", gq.size(), 3);
    chk("tie_fixed_count", gq0.size(), 3);
    for (int i = 0; i < 3; i++) begin
      g = exp_grant(1, 1, m_last, 1); m_last = g;
      if (g) m_cnt_d++; else m_cnt_i++;
      chk("tie_rr_grant", (i < gq.size()) ? {31'd0, gq[i]} : 32'hXXXX_XXXX, {31'd0, g});
      chk("tie_fixed_grant", (i < gq0.size()) ? {31'd0, gq0[i]} : 32'hXXXX_XXXX,
          {31'd0, exp_grant(1, 1, G_DATA, 0)});
    end
    chk("tie_cnt_inst", cnt_inst, m_cnt_i);
    chk("tie_cnt_data", cnt_data, m_cnt_d);

    // Backpressure on a load
    cyc(); d_read = 1; d_addr = 32'h300; d_wdata = 32'hA5A5_5A5A; d_wstrb = 4'h3; mid();
    for (int c = 0; c < 5; c++) begin
      cyc(); mid();
      chk("bp_m_req_valid", m_req_valid, 1);
      chk("bp_m_addr", m_addr, 32'h300);
      chk("bp_m_we", m_we, 0);
      chk("bp_m_wdata_zero", m_wdata, 0);
      chk("bp_m_wstrb_zero", m_wstrb, 0);
      chk("bp_d_req_ready", d_req_ready, 0);
    end
    cyc(); m_req_ready = 1; mid();
    chk("bp_d_req_ready_hs", d_req_ready, 1);
    g = exp_grant(0, 1, m_last, 1); m_last = g; m_cnt_d++;
    cyc(); m_req_ready = 0; d_read = 0; m_rvalid = 1; m_rdata = 32'hCAFE_F00D; mid();
    for (int c = 0; c < 3; c++) begin
      chk("bp_m_rready_hold", m_rready, 0);
      chk("bp_d_rvalid_hold", d_rvalid, 1);
      if (c < 2) begin cyc(); mid(); end
    end
    cyc(); d_rready = 1; mid();
    chk("bp_m_rready", m_rready, 1);
    chk("bp_d_rdata", d_rdata, 32'hCAFE_F00D);
    cyc(); m_rvalid = 0; d_rready = 0; mid();
    chk_all_idle("bp_done");
    chk("bp_cnt_data", cnt_data, m_cnt_d);

    // Reset while in DRSP
    cyc(); d_read = 1; d_addr = 32'h600; m_req_ready = 1; mid();
    cyc(); mid();
    cyc(); d_read = 0; m_req_ready = 0; mid();
    chk("rst_in_drsp_pre", d_rvalid, 0);
    cyc(); rst = 1; m_rvalid = 1; d_rready = 0; mid();
    cyc(); d_rready = 1; inst_rready = 1; m_req_ready = 1; mid();
    chk_all_idle("rst_drsp");
    m_last = G_DATA; m_cnt_i = 0; m_cnt_d = 0;
    chk("rst_drsp_cnt_inst", cnt_inst, m_cnt_i);
    chk("rst_drsp_cnt_data", cnt_data, m_cnt_d);
    cyc(); rst = 0; m_rvalid = 0; d_rready = 0; inst_rready = 0; m_req_ready = 0; mid();
    chk_all_idle("rst_release");

    // Randomized transactions against the reference model
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(1, 3);
      p_i = sel[0]; p_d = sel[1];
      dk  = $urandom_range(0, 2);
      wr  = (dk != 0);
      ia  = $urandom & 32'hFFFF_FFFC;
      da  = $urandom & 32'hFFFF_FFFC;
      dw  = $urandom;
      ds  = 4'($urandom_range(1, 15));
      cyc();
      inst_req_valid = p_i; inst_addr = ia;
      d_read = p_d && (dk != 1); d_write = p_d && (dk != 0);
      d_addr = da; d_wdata = dw; d_wstrb = ds;
      mid();
      while (p_i || p_d) begin
        g = exp_grant(p_i, p_d, m_last, 1); m_last = g;
        got = 0;
        for (int w = 0; w < 4 && !got; w++) begin
          cyc(); mid();
          if (m_req_valid === 1'b1) got = 1;
        end
        chk("rnd_req_seen", got, 1);
        if (!got) begin
          p_i = 0; p_d = 0;
        end else begin
          exp_we = g && wr;
          chk("rnd_m_we", m_we, exp_we);
          chk("rnd_m_addr", m_addr, g ? da : ia);
          chk("rnd_m_wdata", m_wdata, exp_we ? dw : 32'd0);
          chk("rnd_m_wstrb", m_wstrb, exp_we ? {28'd0, ds} : 32'd0);
          chk("rnd_ready_early", {inst_req_ready, d_req_ready}, 0);
          k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            cyc(); mid();
            chk("rnd_stall_valid", m_req_valid, 1);
            chk("rnd_stall_addr", m_addr, g ? da : ia);
          end
          cyc(); m_req_ready = 1; mid();
          chk("rnd_req_ready", {inst_req_ready, d_req_ready}, g ? 2'b01 : 2'b10);
          if (g) m_cnt_d++; else m_cnt_i++;
          cyc(); m_req_ready = 0;
          if (g) begin d_read = 0; d_write = 0; p_d = 0; end
          else begin inst_req_valid = 0; p_i = 0; end
          mid();
          if (exp_we) begin
            chk("rnd_wr_idle", m_req_valid, 0);
            chk("rnd_wr_no_rvalid", d_rvalid, 0);
          end else begin
            chk("rnd_rsp_wait_rvalid", g ? d_rvalid : inst_rvalid, 0);
            chk("rnd_rsp_wait_rready", m_rready, 0);
            r = $urandom_range(0, 2);
            for (int j = 0; j < r; j++) begin
              cyc(); mid();
              chk("rnd_rsp_gap_rvalid", g ? d_rvalid : inst_rvalid, 0);
            end
            rd = $urandom;
            cyc(); m_rvalid = 1; m_rdata = rd; mid();
            q = $urandom_range(0, 2);
            for (int j = 0; j < q; j++) begin
              chk("rnd_rready_hold", m_rready, 0);
              chk("rnd_rvalid_hold", g ? d_rvalid : inst_rvalid, 1);
              cyc(); mid();
            end
            cyc();
            if (g) d_rready = 1; else inst_rready = 1;
            mid();
            chk("rnd_m_rready", m_rready, 1);
            chk("rnd_rvalid", g ? d_rvalid : inst_rvalid, 1);
            chk("rnd_other_rvalid", g ? inst_rvalid : d_rvalid, 0);
            chk("rnd_rdata", g ? d_rdata : inst_rdata, rd);
            cyc(); m_rvalid = 0; inst_rready = 0; d_rready = 0; mid();
            chk("rnd_rsp_idle_rready", m_rready, 0);
            chk("rnd_rsp_idle_rvalid", {inst_rvalid, d_rvalid}, 0);
          end
        end
      end
      chk("rnd_cnt_inst", cnt_inst, m_cnt_i);
      chk("rnd_cnt_data", cnt_data, m_cnt_d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
